pin_uart_rx: RTL

PIN_UART_RX -- requirements
Module: pin_uart_rx

---
 rtl/pin_uart_pkg.sv | 16 +
 rtl/pin_uart_rx_byte.sv | 117 +++++++++++
 rtl/pin_uart_rx.sv | 99 +++++++++
 3 files changed

// File: rtl/pin_uart_pkg.sv
// Shared types and constants for the pin-name UART receiver.
package pin_uart_pkg;

    localparam int CHARS      = 4;
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_e;

endpackage

// File: rtl/pin_uart_rx_byte.sv
// 8N1 byte receiver: rxd synchronizer plus oversampled framing FSM.
// ok/err are combinational and valid only on the stop-bit sample cycle.
//
// state     | meaning
// IDLE      | line idle, waiting for a low sample
// START     | timing to mid start bit to confirm it
// DATA      | shifting in 8 data bits, LSB first
// STOP      | timing to mid stop bit and checking it
// WAIT_HIGH | bad stop bit seen, waiting for the line to return high
module pin_uart_rx_byte
    import pin_uart_pkg::*;
#(
    parameter int OVERSAMPLE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       ok,
    output logic       err,
    output logic       start,
    output logic       idle
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    logic            rxd_meta;
    logic            line;
    rx_state_e       state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [7:0]      shreg, shreg_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            line     <= 1'b1;
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            rxd_meta <= rxd;
            line     <= rxd_meta;
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_idx_n;
            shreg    <= shreg_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        ok        = 1'b0;
        err       = 1'b0;
        start     = 1'b0;
        if (sample) begin
            case (state)
                IDLE: begin
                    if (!line) begin
                        state_n = START;
                        cnt_n   = '0;
                        start   = 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt_n     = '0;
                        bit_idx_n = '0;
                        state_n   = line ? IDLE : DATA;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt_n     = '0;
                        shreg_n   = {line, shreg[7:1]};
                        bit_idx_n = bit_idx + 3'd1;
                        if (bit_idx == LAST_BIT) state_n = STOP;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt_n = '0;
                        if (line) begin
                            ok      = 1'b1;
                            state_n = IDLE;
                        end else begin
                            err     = 1'b1;
                            state_n = WAIT_HIGH;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (line) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign data = shreg;
    assign idle = (state == IDLE);

endmodule

// File: rtl/pin_uart_rx.sv
// Receives 4-character pin names over 8N1 UART and publishes complete names.
// Define PIN_UART_RX_MATCH_EN to compare each new name against EXPECT.
module pin_uart_rx
    import pin_uart_pkg::*;
#(
    parameter int          OVERSAMPLE   = 8,
    parameter int          IDLE_TIMEOUT = 16,
    parameter logic [31:0] EXPECT       = "AF12"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample,
    input  logic        rxd,
    output logic [31:0] name,
    output logic        name_valid,
    output logic        frame_err,
    output logic        match
);

    localparam int IDLE_LIMIT = IDLE_TIMEOUT * OVERSAMPLE;
    localparam int IW         = $clog2(IDLE_LIMIT + 1);
    localparam logic [1:0] LAST_CHAR = 2'(CHARS - 1);

    logic [7:0]    rx_data;
    logic          rx_ok;
    logic          rx_err;
    logic          rx_start;
    logic          rx_idle;
    logic [23:0]   partial;
    logic [1:0]    byte_cnt;
    logic [IW-1:0] idle_cnt;
    logic          name_load;

    pin_uart_rx_byte #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_byte (
        .clk    (clk),
        .rst    (rst),
        .sample (sample),
        .rxd    (rxd),
        .data   (rx_data),
        .ok     (rx_ok),
        .err    (rx_err),
        .start  (rx_start),
        .idle   (rx_idle)
    );

    assign name_load = sample && rx_ok && (byte_cnt == LAST_CHAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            name       <= '0;
            name_valid <= 1'b0;
            frame_err  <= 1'b0;
            partial    <= '0;
            byte_cnt   <= '0;
            idle_cnt   <= '0;
        end else begin
            name_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (sample) begin
                if (rx_ok) begin
                    partial  <= {partial[15:0], rx_data};
                    byte_cnt <= byte_cnt + 2'd1;
                    if (name_load) begin
                        name       <= {partial, rx_data};
                        name_valid <= 1'b1;
                    end
                end else if (rx_err) begin
                    frame_err <= 1'b1;
                    byte_cnt  <= '0;
                    partial   <= '0;
                end
                // A stalled partial name is dropped once the line stays idle too long.
                if (rx_start) begin
                    idle_cnt <= '0;
                end else if (rx_idle && byte_cnt != 2'd0) begin
                    if (idle_cnt == IW'(IDLE_LIMIT - 1)) begin
                        idle_cnt <= IW'(IDLE_LIMIT);
                        byte_cnt <= '0;
                        partial  <= '0;
                    end else if (idle_cnt != IW'(IDLE_LIMIT)) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
            end
        end
    end

`ifdef PIN_UART_RX_MATCH_EN
    always_ff @(posedge clk) begin
        if (rst)            match <= 1'b0;
        else if (name_load) match <= ({partial, rx_data} == EXPECT);
    end
`else
    assign match = 1'b0;
`endif

endmodule
